// File: rtl/mem_arbiter_pipeline_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM state, owner encoding,
// the latched command record and default timeout settings.
package mem_arbiter_pipeline_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_cmd_t;

    localparam int TIMEOUT_DEFAULT = 1024;
    localparam int CNT_W_DEFAULT   = 10;

endpackage

// File: rtl/mem_arb_req_slot.sv
// One requester's pending slot: holds a pulsed request until granted, and
// bypasses the incoming pulse so it can be granted on the edge that samples it.
module mem_arb_req_slot
    import mem_arbiter_pipeline_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     req,
    input  mem_cmd_t cmd_in,
    input  logic     kill,
    input  logic     grant,
    output logic     cand,
    output mem_cmd_t cmd
);

    logic     pending;
    mem_cmd_t held;

    // A fresh pulse always survives a kill in the same cycle.
    assign cand = req | (pending & ~kill);
    assign cmd  = req ? cmd_in : held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            held    <= '0;
        end else begin
            if (req) begin
                held <= cmd_in;
            end
            if (grant) begin
                pending <= 1'b0;
            end else if (req) begin
                pending <= 1'b1;
            end else if (kill) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_pipeline.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one
// outstanding transaction. Optional response timeout: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter_pipeline
    import mem_arbiter_pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    input  logic        ifu_flush,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t  state;
    owner_t      owner;
    owner_t      last_grant;
    owner_t      win_owner;
    logic        drop;
    logic        ifu_cand, lsu_cand;
    logic        ifu_grant, lsu_grant, issue, arb_open;
    logic        done, synth;
    logic [31:0] resp_data;
    mem_cmd_t    ifu_cmd_in, lsu_cmd_in, ifu_cmd, lsu_cmd, win_cmd;

    assign ifu_cmd_in = '{wen: 1'b0, addr: ifu_addr, wdata: 32'h0, wmask: 4'h0};
    assign lsu_cmd_in = '{wen: lsu_wen, addr: lsu_addr, wdata: lsu_wdata, wmask: lsu_wmask};

    mem_arb_req_slot u_ifu_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (ifu_req),
        .cmd_in (ifu_cmd_in),
        .kill   (ifu_flush),
        .grant  (ifu_grant),
        .cand   (ifu_cand),
        .cmd    (ifu_cmd)
    );

    mem_arb_req_slot u_lsu_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (lsu_req),
        .cmd_in (lsu_cmd_in),
        .kill   (1'b0),
        .grant  (lsu_grant),
        .cand   (lsu_cand),
        .cmd    (lsu_cmd)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    assign synth = (state == ARB_WAIT) && !mem_rvalid && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (issue) begin
                wait_cnt <= '0;
            end else if (state == ARB_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (synth) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_LAST;
    assign synth              = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // Stray responses in IDLE never count as completions.
    assign done      = (state == ARB_WAIT) && (mem_rvalid || synth);
    assign resp_data = synth ? 32'h0 : mem_rdata;

    assign ifu_rvalid = done && (owner == OWN_IFU) && !drop && !ifu_flush;
    assign lsu_rvalid = done && (owner == OWN_LSU);
    assign ifu_rdata  = ifu_rvalid ? resp_data : 32'h0;
    assign lsu_rdata  = lsu_rvalid ? resp_data : 32'h0;

    // Arbitrating in the completion cycle lets the next mem_req follow the
    // response by exactly one cycle without overlapping it.
    assign arb_open = (state == ARB_IDLE) || done;

    always_comb begin
        ifu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (arb_open) begin
            if (ifu_cand && lsu_cand) begin
                if (last_grant == OWN_IFU) begin
                    lsu_grant = 1'b1;
                end else begin
                    ifu_grant = 1'b1;
                end
            end else if (ifu_cand) begin
                ifu_grant = 1'b1;
            end else if (lsu_cand) begin
                lsu_grant = 1'b1;
            end
        end
    end

    assign issue     = ifu_grant | lsu_grant;
    assign win_cmd   = lsu_grant ? lsu_cmd : ifu_cmd;
    assign win_owner = lsu_grant ? OWN_LSU : OWN_IFU;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            drop       <= 1'b0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 4'h0;
        end else begin
            mem_req <= 1'b0;
            if (issue) begin
                state      <= ARB_WAIT;
                busy       <= 1'b1;
                mem_req    <= 1'b1;
                mem_wen    <= win_cmd.wen;
                mem_addr   <= win_cmd.addr;
                mem_wdata  <= win_cmd.wdata;
                mem_wmask  <= win_cmd.wen ? win_cmd.wmask : 4'h0;
                owner      <= win_owner;
                last_grant <= win_owner;
                drop       <= 1'b0;
            end else if (done) begin
                state <= ARB_IDLE;
                busy  <= 1'b0;
                drop  <= 1'b0;
            end else if (state == ARB_WAIT && ifu_flush && owner == OWN_IFU) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter_pipeline.md
Name: mem_arbiter_pipeline

Overview:
Shares the single SoC memory port between the pipeline IFU (read-only fetch) and the LSU (load/store). Both requesters use the pipeline memory protocol: a one-cycle req pulse with address/data, then one rvalid pulse returning rdata. Stores also complete with an rvalid pulse. The block latches pulsed requests, arbitrates round-robin, and allows one outstanding downstream transaction. It routes each response back to its owner and drops fetch responses killed by a pipeline flush.

Parameters:
TIMEOUT_CYCLES, 1024, WAIT-state cycles before a synthetic response is generated (only used with the optional feature).
CNT_W, 10, width of the timeout counter; CNT_W must be at least clog2(TIMEOUT_CYCLES).

Ports:
clk  in  1  clock; all state is updated on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
ifu_req  in  1  one-cycle fetch request pulse.
ifu_addr  in  32  fetch address, valid while ifu_req=1.
ifu_flush  in  1  pipeline redirect; kills any pending or in-flight fetch.
ifu_rvalid  out  1  fetch response pulse.
ifu_rdata  out  32  fetch data, valid with ifu_rvalid.
lsu_req  in  1  one-cycle access request pulse.
lsu_wen  in  1  1 = store, 0 = load; sampled with lsu_req.
lsu_addr  in  32  access address; sampled with lsu_req.
lsu_wdata  in  32  store data, already byte-aligned; sampled with lsu_req.
lsu_wmask  in  4  store byte mask; sampled with lsu_req.
lsu_rvalid  out  1  access-complete pulse, for both loads and stores.
lsu_rdata  out  32  raw 32-bit load word, valid with lsu_rvalid.
mem_req  out  1  downstream request pulse, driven from a register.
mem_wen  out  1  downstream write enable.
mem_addr  out  32  downstream address.
mem_wdata  out  32  downstream write data.
mem_wmask  out  4  downstream byte mask; 4'b0000 for fetches and loads.
mem_rvalid  in  1  downstream response pulse.
mem_rdata  in  32  downstream response data.
busy  out  1  1 while a downstream transaction is outstanding.
timeout_err  out  1  sticky flag, set when a transaction times out.

Behaviour:
- Reset values: all outputs 0; state=IDLE; pending flags 0; last_grant=IFU, so the LSU wins the first tie; drop=0.
- Request capture: each requester has a pending register that holds the request's fields. A req pulse sets pending on the same edge.
- Protocol rule: a requester never pulses req while its own request is pending or in flight. The bench asserts this; the RTL behaviour on violation is undefined.
- State machine states are IDLE and WAIT.
- IDLE:
  - The candidate set for each requester is pending OR the incoming req (a bypass), so a request can issue on the edge that samples it.
  - If either is a candidate, grant one, load the mem_* registers, pulse mem_req=1 for exactly one cycle, clear the winner's pending flag, record the owner, and go to WAIT.
  - Best-case latency: req high in cycle T, then mem_req high in cycle T+1.
- Arbitration: if only one requester is a candidate, it wins. If both are, the one that is not last_grant wins. last_grant is updated on every grant.
- WAIT:
  - busy=1 and mem_req=0.
  - On mem_rvalid, the owner's rvalid goes high combinationally in the same cycle, with rdata = mem_rdata; the other requester's rvalid stays 0. Then go to IDLE.
  - The next issue is no earlier than the cycle after mem_rvalid, so the response and the next mem_req never overlap.
  - Requests from the non-owner arriving during WAIT are latched in pending and are not lost.
- Flush:
  - ifu_flush clears a pending IFU request.
  - If ifu_req and ifu_flush are high in the same cycle, the request survives, because it is the redirected fetch.
  - If the owner is the IFU in WAIT, set drop. The response is then consumed with ifu_rvalid held at 0, and drop is cleared.
  - Flush has no effect on the LSU.
- Reset mid-transaction: everything returns to reset values. A later stray mem_rvalid arriving in IDLE is ignored.
- Widths: address and data pass through unmodified; the arbiter does no alignment.

Optional Feature:
MEM_ARB_TIMEOUT_EN.
- With the macro: a counter clears on issue and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without mem_rvalid, the arbiter:
  - pulses the owner's rvalid with rdata=32'h0 (drop still applies to the IFU);
  - sets timeout_err (sticky until reset);
  - returns to IDLE.
  A late mem_rvalid that arrives in IDLE is discarded.
- Without the macro: no counter is built, timeout_err is tied to 0, and WAIT lasts indefinitely.

Decomposition:
- Shared pipeline package: state encoding (ARB_IDLE, ARB_WAIT), owner encoding (OWN_IFU=0, OWN_LSU=1), TIMEOUT default.
- One natural sub-module, mem_arb_req_slot: the pending register plus field latch and the bypass mux. It is instantiated twice; the IFU instance ties wen, wdata and wmask to 0.

Test Plan:
- Single fetch: ifu_req at addr 0x3000_0000 in cycle 0; mem_rvalid in cycle 4 with rdata 0x0000_0413. Expect mem_req in cycle 1 with mem_wmask=0, then ifu_rvalid in cycle 4 with rdata 0x0000_0413, and lsu_rvalid=0 throughout.
- Simultaneous requests after reset: ifu_req and lsu_req in the same cycle, with lsu being a store, addr 0x8000_0004, wdata 0x0000_AB00, mask 4'b0010. Expect the LSU granted first with mem_wen=1; after its rvalid, the IFU is issued in the following cycle.
- Round-robin: both requesters continuously re-request for 6 grants. Expect owners alternating L, I, L, I, L, I.
- Flush in flight: fetch outstanding, ifu_flush pulsed, then mem_rvalid. Expect ifu_rvalid=0 and busy dropping to 0. A new ifu_req issues normally afterwards.
- Pending during WAIT: an LSU load is in flight when ifu_req pulses in the middle of WAIT. The fetch is latched, then mem_req for it is asserted exactly one cycle after the load's mem_rvalid.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: no mem_rvalid arrives. Expect the owner's rvalid with rdata 0 after 16 WAIT cycles, timeout_err=1, and a late mem_rvalid ignored.
